// File: rtl/line_clipper.sv
// line_clipper: Cohen-Sutherland clipper between the AVG line output and the
// rasterizer line queue. Segments arrive in signed CW-bit screen coordinates
// and leave clipped to the window [0,XMAX] x [0,YMAX]. Each intersection uses
// one multiply cycle and a restoring divider. Invisible or zero-intensity
// segments are dropped and counted.
//
// Ports:
//   clk, rst_l                      clock, asynchronous active-low reset
//   in_valid/in_ready               input handshake (ready only when idle)
//   in_start_x/y, in_end_x/y        raw signed endpoints
//   in_intensity                    line intensity (0 means drop)
//   out_valid/out_ready             output handshake, data held until taken
//   out_start_x/y, out_end_x/y      clipped endpoints, always in the window
//   out_intensity                   intensity, passed through
//   busy                            high whenever not idle
//   drop_count                      saturating count of discarded segments
module line_clipper #(
  parameter int CW   = 13,
  parameter int XMAX = 639,
  parameter int YMAX = 479
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [CW-1:0] in_start_x,
  input  logic signed [CW-1:0] in_start_y,
  input  logic signed [CW-1:0] in_end_x,
  input  logic signed [CW-1:0] in_end_y,
  input  logic [3:0]           in_intensity,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [CW-1:0] out_start_x,
  output logic signed [CW-1:0] out_start_y,
  output logic signed [CW-1:0] out_end_x,
  output logic signed [CW-1:0] out_end_y,
  output logic [3:0]           out_intensity,
  output logic                 busy,
  output logic [15:0]          drop_count
);

  localparam int PW   = 2 * (CW + 1);
  localparam int CntW = $clog2(CW);

  typedef logic signed [CW-1:0] coord_t;
  typedef logic signed [CW:0]   wide_t;

  localparam coord_t XMaxC = coord_t'(XMAX);
  localparam coord_t YMaxC = coord_t'(YMAX);

  typedef enum logic [2:0] {StIdle, StCode, StMul, StDiv, StUpdate, StOut} state_e;

  // Outcode bits: {top, bottom, right, left}. Points on an edge are inside.
  function automatic logic [3:0] outcode(input coord_t x, input coord_t y);
    outcode = {y[CW-1], (y > YMaxC), (x > XMaxC), x[CW-1]};
  endfunction

  function automatic wide_t sext(input coord_t v);
    sext = {v[CW-1], v};
  endfunction

  state_e            state_q, state_d;
  coord_t            x0_q, y0_q, x1_q, y1_q;
  coord_t            x0_d, y0_d, x1_d, y1_d;
  logic [3:0]        inten_q, inten_d;
  logic [15:0]       drop_q, drop_d;
  logic              move_p0_q, move_p0_d;
  logic              vert_q, vert_d;
  logic              neg_q, neg_d;
  coord_t            edge_q, edge_d;
  logic [CW:0]       rem_q, rem_d;
  logic [CW:0]       quo_q, quo_d;
  logic [CW:0]       den_q, den_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  // Clip-pass setup datapath, valid while in StMul
  logic [3:0]  c0, c1, code_m;
  logic        move_p0, vert;
  coord_t      xm, ym, edge_v;
  wide_t       dx, dy, delta, mul_a, den;
  logic [PW-1:0] prod, abs_num;
  logic [CW:0] abs_den;

  always_comb begin
    c0      = outcode(x0_q, y0_q);
    c1      = outcode(x1_q, y1_q);
    move_p0 = (c0 != 4'b0000);
    code_m  = move_p0 ? c0 : c1;
    xm      = move_p0 ? x0_q : x1_q;
    ym      = move_p0 ? y0_q : y1_q;
    dx      = sext(x1_q) - sext(x0_q);
    dy      = sext(y1_q) - sext(y0_q);
    vert    = code_m[0] | code_m[1];
    // Edge priority: left, right, top, bottom
    if (code_m[0])      edge_v = '0;
    else if (code_m[1]) edge_v = XMaxC;
    else if (code_m[3]) edge_v = '0;
    else                edge_v = YMaxC;
    delta   = vert ? (sext(edge_v) - sext(xm)) : (sext(edge_v) - sext(ym));
    mul_a   = vert ? dy : dx;
    den     = vert ? dx : dy;
    // Low PW bits of the wrapped product equal the signed product
    prod    = {{(CW + 1){mul_a[CW]}}, mul_a} * {{(CW + 1){delta[CW]}}, delta};
    abs_num = prod[PW-1] ? (~prod + 1'b1) : prod;
    abs_den = den[CW] ? (~den + 1'b1) : den;
  end

  // One restoring step; shared by StDiv and the final bit taken in StUpdate.
  // The quotient fits in CW+1 bits, so the upper half of |num| starts below den.
  logic [CW+1:0] trial;
  logic          ge;
  logic [CW:0]   diff, rem_step, quo_step;
  coord_t        q_lo, q_s, mov_other, new_other;

  always_comb begin
    trial     = {rem_q, quo_q[CW]};
    ge        = (trial >= {1'b0, den_q});
    diff      = trial[CW:0] - den_q;
    rem_step  = ge ? diff : trial[CW:0];
    quo_step  = {quo_q[CW-1:0], ge};
    q_lo      = quo_step[CW-1:0];
    q_s       = neg_q ? (~q_lo + 1'b1) : q_lo;
    if (vert_q) mov_other = move_p0_q ? y0_q : y1_q;
    else        mov_other = move_p0_q ? x0_q : x1_q;
    // Result lies inside the window, so CW-bit wraparound is harmless
    new_other = mov_other + q_s;
  end

  always_comb begin
    state_d   = state_q;
    x0_d      = x0_q;
    y0_d      = y0_q;
    x1_d      = x1_q;
    y1_d      = y1_q;
    inten_d   = inten_q;
    drop_d    = drop_q;
    move_p0_d = move_p0_q;
    vert_d    = vert_q;
    neg_d     = neg_q;
    edge_d    = edge_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    den_d     = den_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          x0_d    = in_start_x;
          y0_d    = in_start_y;
          x1_d    = in_end_x;
          y1_d    = in_end_y;
          inten_d = in_intensity;
          state_d = StCode;
        end
      end
      StCode: begin
        if ((inten_q == 4'd0) || ((c0 & c1) != 4'b0000)) begin
          drop_d  = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
          state_d = StIdle;
        end else if ((c0 | c1) == 4'b0000) begin
          state_d = StOut;
        end else begin
          state_d = StMul;
        end
      end
      StMul: begin
        move_p0_d = move_p0;
        vert_d    = vert;
        edge_d    = edge_v;
        neg_d     = prod[PW-1] ^ den[CW];
        rem_d     = abs_num[PW-1:CW+1];
        quo_d     = abs_num[CW:0];
        den_d     = abs_den;
        cnt_d     = CntW'(CW - 1);
        state_d   = StDiv;
      end
      StDiv: begin
        rem_d = rem_step;
        quo_d = quo_step;
        if (cnt_q == '0) state_d = StUpdate;
        else             cnt_d   = cnt_q - 1'b1;
      end
      StUpdate: begin
        // Last quotient bit is resolved here alongside the endpoint write
        if (move_p0_q) begin
          if (vert_q) begin x0_d = edge_q; y0_d = new_other; end
          else        begin y0_d = edge_q; x0_d = new_other; end
        end else begin
          if (vert_q) begin x1_d = edge_q; y1_d = new_other; end
          else        begin y1_d = edge_q; x1_d = new_other; end
        end
        state_d = StCode;
      end
      StOut: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q   <= StIdle;
      x0_q      <= '0;
      y0_q      <= '0;
      x1_q      <= '0;
      y1_q      <= '0;
      inten_q   <= '0;
      drop_q    <= '0;
      move_p0_q <= 1'b0;
      vert_q    <= 1'b0;
      neg_q     <= 1'b0;
      edge_q    <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      den_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      x0_q      <= x0_d;
      y0_q      <= y0_d;
      x1_q      <= x1_d;
      y1_q      <= y1_d;
      inten_q   <= inten_d;
      drop_q    <= drop_d;
      move_p0_q <= move_p0_d;
      vert_q    <= vert_d;
      neg_q     <= neg_d;
      edge_q    <= edge_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      den_q     <= den_d;
      cnt_q     <= cnt_d;
    end
  end

  assign in_ready      = (state_q == StIdle);
  assign out_valid     = (state_q == StOut);
  assign busy          = (state_q != StIdle);
  assign out_start_x   = x0_q;
  assign out_start_y   = y0_q;
  assign out_end_x     = x1_q;
  assign out_end_y     = y1_q;
  assign out_intensity = inten_q;
  assign drop_count    = drop_q;

endmodule

// File: tb/tb_line_clipper.sv
module tb_line_clipper;

  logic               clk;
  logic               rst_l;
  logic               in_valid;
  logic               in_ready;
  logic signed [12:0] in_start_x, in_start_y, in_end_x, in_end_y;
  logic [3:0]         in_intensity;
  logic               out_valid;
  logic               out_ready;
  logic signed [12:0] out_start_x, out_start_y, out_end_x, out_end_y;
  logic [3:0]         out_intensity;
  logic               busy;
  logic [15:0]        drop_count;

  int n_chk;
  int n_fail;

  line_clipper #(.CW(13), .XMAX(639), .YMAX(479)) dut (
    .clk          (clk),
    .rst_l        (rst_l),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_start_x   (in_start_x),
    .in_start_y   (in_start_y),
    .in_end_x     (in_end_x),
    .in_end_y     (in_end_y),
    .in_intensity (in_intensity),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_start_x  (out_start_x),
    .out_start_y  (out_start_y),
    .out_end_x    (out_end_x),
    .out_end_y    (out_end_y),
    .out_intensity(out_intensity),
    .busy         (busy),
    .drop_count   (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offers one segment; returns #1 after the transfer edge (DUT then in CODE).
  task automatic send(input int sx, input int sy, input int ex, input int ey, input int inten);
    in_start_x   = 13'(sx);
    in_start_y   = 13'(sy);
    in_end_x     = 13'(ex);
    in_end_y     = 13'(ey);
    in_intensity = 4'(inten);
    in_valid     = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Latency counted with the CODE cycle right after the transfer as cycle 1;
  // -1 means out_valid never came within the budget.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic take_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_chk++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_flags: got rdy/vld/busy=%b expected 100", {in_ready, out_valid, busy});
    end
    n_chk++;
    if (drop_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_drop: got %0d expected 0", drop_count);
    end
    n_chk++;
    if ({out_start_x, out_start_y, out_end_x, out_end_y, out_intensity} !== 56'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %0d,%0d-%0d,%0d i%0d expected all 0",
               out_start_x, out_start_y, out_end_x, out_end_y, out_intensity);
    end
  endtask

  task automatic test_trivial_accept();
    int lat;
    send(10, 20, 300, 400, 7);
    wait_out(lat);
    n_chk++;
    if (lat !== 2) begin
      n_fail++;
      $display("FAIL accept_latency: got %0d expected 2", lat);
    end
    n_chk++;
    if ({out_start_x, out_start_y, out_end_x, out_end_y, out_intensity} !==
        {13'sd10, 13'sd20, 13'sd300, 13'sd400, 4'd7}) begin
      n_fail++;
      $display("FAIL accept_data: got %0d,%0d-%0d,%0d i%0d expected 10,20-300,400 i7",
               out_start_x, out_start_y, out_end_x, out_end_y, out_intensity);
    end
    n_chk++;
    if ({busy, in_ready, drop_count} !== {1'b1, 1'b0, 16'd0}) begin
      n_fail++;
      $display("FAIL accept_status: got busy=%b rdy=%b drop=%0d expected 1 0 0",
               busy, in_ready, drop_count);
    end
    take_out();
  endtask

  task automatic test_trivial_reject();
    bit saw_valid;
    int waited;
    saw_valid = out_valid;
    send(-50, -5, -1, 300, 7);
    waited = 0;
    while (!in_ready && waited < 2) begin
      @(posedge clk);
      #1;
      waited++;
      if (out_valid) saw_valid = 1'b1;
    end
    n_chk++;
    if ({saw_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL reject_handshake: got valid_seen=%b rdy=%b expected 0 1", saw_valid, in_ready);
    end
    n_chk++;
    if (drop_count !== 16'd1) begin
      n_fail++;
      $display("FAIL reject_drop: got %0d expected 1", drop_count);
    end
  endtask

  task automatic test_single_clip();
    int lat;
    send(-10, 0, 10, 20, 9);
    wait_out(lat);
    n_chk++;
    if (lat !== 18) begin
      n_fail++;
      $display("FAIL single_latency: got %0d expected 18", lat);
    end
    n_chk++;
    if ({out_start_x, out_start_y, out_end_x, out_end_y} !== {13'sd0, 13'sd10, 13'sd10, 13'sd20}) begin
      n_fail++;
      $display("FAIL single_data: got %0d,%0d-%0d,%0d expected 0,10-10,20",
               out_start_x, out_start_y, out_end_x, out_end_y);
    end
    take_out();
  endtask

  task automatic test_double_clip();
    int lat;
    // Left, then right, then bottom: three passes
    send(-10, -10, 700, 700, 15);
    wait_out(lat);
    n_chk++;
    if (lat !== 50) begin
      n_fail++;
      $display("FAIL double_latency: got %0d expected 50", lat);
    end
    n_chk++;
    if ({out_start_x, out_start_y, out_end_x, out_end_y, out_intensity} !==
        {13'sd0, 13'sd0, 13'sd479, 13'sd479, 4'd15}) begin
      n_fail++;
      $display("FAIL double_data: got %0d,%0d-%0d,%0d i%0d expected 0,0-479,479 i15",
               out_start_x, out_start_y, out_end_x, out_end_y, out_intensity);
    end
    take_out();
    send(-20, 100, 20, 60, 2);
    wait_out(lat);
    n_chk++;
    if ({out_start_x, out_start_y, out_end_x, out_end_y} !== {13'sd0, 13'sd80, 13'sd20, 13'sd60}) begin
      n_fail++;
      $display("FAIL negslope_data: got %0d,%0d-%0d,%0d expected 0,80-20,60",
               out_start_x, out_start_y, out_end_x, out_end_y);
    end
    take_out();
    // Moving endpoint is P1 here, order must be preserved
    send(10, 20, -10, 0, 4);
    wait_out(lat);
    n_chk++;
    if ({out_start_x, out_start_y, out_end_x, out_end_y} !== {13'sd10, 13'sd20, 13'sd0, 13'sd10}) begin
      n_fail++;
      $display("FAIL p1_clip_data: got %0d,%0d-%0d,%0d expected 10,20-0,10",
               out_start_x, out_start_y, out_end_x, out_end_y);
    end
    take_out();
  endtask

  task automatic test_boundaries();
    int lat;
    send(0, 0, 639, 479, 1);
    wait_out(lat);
    n_chk++;
    if (lat !== 2 ||
        {out_start_x, out_start_y, out_end_x, out_end_y} !== {13'sd0, 13'sd0, 13'sd639, 13'sd479}) begin
      n_fail++;
      $display("FAIL edge_points: got lat=%0d %0d,%0d-%0d,%0d expected lat=2 0,0-639,479",
               lat, out_start_x, out_start_y, out_end_x, out_end_y);
    end
    take_out();
    send(5, 5, 5, 5, 3);
    wait_out(lat);
    n_chk++;
    if (lat !== 2 ||
        {out_start_x, out_start_y, out_end_x, out_end_y} !== {13'sd5, 13'sd5, 13'sd5, 13'sd5}) begin
      n_fail++;
      $display("FAIL zero_length: got lat=%0d %0d,%0d-%0d,%0d expected lat=2 5,5-5,5",
               lat, out_start_x, out_start_y, out_end_x, out_end_y);
    end
    take_out();
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    bit saw_valid;
    send(1, 2, 3, 4, 5);
    wait_out(lat);
    bad = (lat == 2) ? 0 : 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (!out_valid || in_ready ||
          {out_start_x, out_start_y, out_end_x, out_end_y, out_intensity} !==
          {13'sd1, 13'sd2, 13'sd3, 13'sd4, 4'd5}) bad++;
    end
    n_chk++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL backpressure_hold: got %0d unstable cycles expected 0", bad);
    end
    take_out();
    n_chk++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL backpressure_release: got vld/rdy=%b expected 01", {out_valid, in_ready});
    end
    send(5, 5, 6, 6, 0);
    saw_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) saw_valid = 1'b1;
    end
    n_chk++;
    if ({saw_valid, in_ready, drop_count} !== {1'b0, 1'b1, 16'd2}) begin
      n_fail++;
      $display("FAIL zero_intensity: got valid_seen=%b rdy=%b drop=%0d expected 0 1 2",
               saw_valid, in_ready, drop_count);
    end
  endtask

  task automatic test_reset_mid_div();
    int lat;
    send(-10, 0, 10, 20, 6);
    repeat (5) @(posedge clk);
    #3;
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL middiv_busy: got %b expected 1", busy);
    end
    rst_l = 1'b0;
    #1;
    n_chk++;
    if ({out_valid, in_ready, busy, drop_count} !== {1'b0, 1'b1, 1'b0, 16'd0}) begin
      n_fail++;
      $display("FAIL middiv_reset: got vld=%b rdy=%b busy=%b drop=%0d expected 0 1 0 0",
               out_valid, in_ready, busy, drop_count);
    end
    @(posedge clk);
    #2;
    rst_l = 1'b1;
    @(posedge clk);
    #1;
    send(100, 100, 200, 50, 3);
    wait_out(lat);
    n_chk++;
    if (lat !== 2 ||
        {out_start_x, out_start_y, out_end_x, out_end_y, out_intensity} !==
        {13'sd100, 13'sd100, 13'sd200, 13'sd50, 4'd3}) begin
      n_fail++;
      $display("FAIL after_reset: got lat=%0d %0d,%0d-%0d,%0d i%0d expected lat=2 100,100-200,50 i3",
               lat, out_start_x, out_start_y, out_end_x, out_end_y, out_intensity);
    end
    take_out();
  endtask

  initial begin
    n_chk        = 0;
    n_fail       = 0;
    rst_l        = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    in_start_x   = '0;
    in_start_y   = '0;
    in_end_x     = '0;
    in_end_y     = '0;
    in_intensity = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_l = 1'b1;
    @(posedge clk);
    #1;
    test_trivial_accept();
    test_trivial_reject();
    test_single_clip();
    test_double_clip();
    test_boundaries();
    test_backpressure();
    test_reset_mid_div();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
